board_io_adapter: RTL and testbench

Parametrised board-level I/O adapter between the physical development board and the game core. It synchronises and debounces N raw push-buttons into clean levels plus one-cycle press/release pulses. It registers and expands the core's narrow VGA colour channels to the board's 5-bit-per-channel RGB bus. It drives status LEDs, including a blink pattern for game-over and win.

---
 rtl/board_io_adapter_if.sv | 33 +++
 rtl/board_io_adapter.sv | 121 ++++++++++++
 tb/tb_board_io_adapter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_io_adapter_if.sv
// Board-side and core-side signal bundle for board_io_adapter.
// The adapter attaches through the slave modport; the core/board side uses master.
interface board_io_adapter_if #(
   parameter int unsigned NUM_BTN     = 4,
   parameter int unsigned COLOR_IN_W  = 1,
   parameter int unsigned COLOR_OUT_W = 5
);
   logic [NUM_BTN-1:0]      btn_raw;
   logic [NUM_BTN-1:0]      btn_level;
   logic [NUM_BTN-1:0]      btn_press;
   logic [NUM_BTN-1:0]      btn_release;
   logic                    hsync_in;
   logic                    vsync_in;
   logic [COLOR_IN_W-1:0]   r_in;
   logic [COLOR_IN_W-1:0]   g_in;
   logic [COLOR_IN_W-1:0]   b_in;
   logic                    game_end;
   logic                    game_win;
   logic                    h_sync;
   logic                    v_sync;
   logic [3*COLOR_OUT_W:0]  rgb;
   logic [NUM_BTN:0]        led;

   modport master (
      output btn_raw, hsync_in, vsync_in, r_in, g_in, b_in, game_end, game_win,
      input  btn_level, btn_press, btn_release, h_sync, v_sync, rgb, led
   );

   modport slave (
      input  btn_raw, hsync_in, vsync_in, r_in, g_in, b_in, game_end, game_win,
      output btn_level, btn_press, btn_release, h_sync, v_sync, rgb, led
   );
endinterface

// File: rtl/board_io_adapter.sv
// Board I/O adapter: button sync/debounce with edge pulses, registered colour
// expansion and sync to the board, and a blinking status LED.
module board_io_adapter #(
   parameter int unsigned NUM_BTN         = 4,
   parameter bit          BTN_ACTIVE_LOW  = 1'b0,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 5,
   parameter int unsigned COLOR_IN_W      = 1,
   parameter int unsigned COLOR_OUT_W     = 5,
   parameter int unsigned BLINK_W         = 24,
   parameter bit          SYNC_IDLE       = 1'b1
) (
   input logic               clk,
   input logic               reset,
   board_io_adapter_if.slave bus
);

   localparam int unsigned       RGB_W    = 3 * COLOR_OUT_W + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BTN-1:0] POL     = {NUM_BTN{BTN_ACTIVE_LOW}};

   logic [NUM_BTN-1:0]            sync1_q;
   logic [NUM_BTN-1:0]            sync2_q;
   logic [NUM_BTN-1:0]            level_q;
   logic [NUM_BTN-1:0]            press_q;
   logic [NUM_BTN-1:0]            release_q;
   logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q;

   logic [NUM_BTN-1:0]            level_d;
   logic [NUM_BTN-1:0]            press_d;
   logic [NUM_BTN-1:0]            release_d;
   logic [NUM_BTN-1:0][CNT_W-1:0] cnt_d;

   logic                          h_sync_q;
   logic                          v_sync_q;
   logic [RGB_W-1:0]              rgb_q;
   logic [RGB_W-1:0]              rgb_d;

   logic [BLINK_W-1:0]            blink_q;
   logic                          status_q;
   logic                          status_d;

   // Replicate the narrow colour MSB-first across the wide channel.
   function automatic logic [COLOR_OUT_W-1:0] expand(input logic [COLOR_IN_W-1:0] c);
      logic [COLOR_OUT_W-1:0] e;
      e = '0;
      for (int k = 0; k < COLOR_OUT_W; k++) begin
         e[COLOR_OUT_W-1-k] = c[COLOR_IN_W-1-(k % COLOR_IN_W)];
      end
      return e;
   endfunction

   // Debounce: a synced level differing from the accepted one must persist
   // DEBOUNCE_CYCLES cycles; any agreeing cycle restarts the count.
   always_comb begin
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      cnt_d     = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i]   = sync2_q[i];
               press_d[i]   = sync2_q[i];
               release_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Video and status next values
   always_comb begin
      rgb_d = {1'b0, expand(bus.r_in), expand(bus.g_in), expand(bus.b_in)};
      if (bus.game_win) begin
         status_d = blink_q[BLINK_W-2];
      end else if (bus.game_end) begin
         status_d = blink_q[BLINK_W-1];
      end else begin
         status_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         cnt_q     <= '0;
         h_sync_q  <= SYNC_IDLE;
         v_sync_q  <= SYNC_IDLE;
         rgb_q     <= '0;
         blink_q   <= '0;
         status_q  <= 1'b0;
      end else begin
         sync1_q   <= bus.btn_raw ^ POL;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         cnt_q     <= cnt_d;
         h_sync_q  <= bus.hsync_in;
         v_sync_q  <= bus.vsync_in;
         rgb_q     <= rgb_d;
         blink_q   <= blink_q + BLINK_W'(1);
         status_q  <= status_d;
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = release_q;
   assign bus.h_sync      = h_sync_q;
   assign bus.v_sync      = v_sync_q;
   assign bus.rgb         = rgb_q;
   assign bus.led         = {level_q, status_q};

endmodule

// File: tb/tb_board_io_adapter.sv
// Directed self-checking bench for board_io_adapter (active-high and active-low instances).
module tb_board_io_adapter;

   localparam int unsigned NB  = 4;
   localparam int unsigned CI  = 2;
   localparam int unsigned CO  = 5;
   localparam int unsigned DEB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   board_io_adapter_if #(.NUM_BTN(NB), .COLOR_IN_W(CI), .COLOR_OUT_W(CO)) bus_a ();
   board_io_adapter_if #(.NUM_BTN(NB), .COLOR_IN_W(CI), .COLOR_OUT_W(CO)) bus_b ();

   board_io_adapter #(
      .NUM_BTN(NB), .BTN_ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DEB), .CNT_W(3),
      .COLOR_IN_W(CI), .COLOR_OUT_W(CO), .BLINK_W(4), .SYNC_IDLE(1'b1)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );

   board_io_adapter #(
      .NUM_BTN(NB), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB), .CNT_W(3),
      .COLOR_IN_W(CI), .COLOR_OUT_W(CO), .BLINK_W(4), .SYNC_IDLE(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus_a.btn_level !== 4'b0 || bus_a.btn_press !== 4'b0 || bus_a.btn_release !== 4'b0) begin
         errors++;
         $display("FAIL reset_btn: level=%b press=%b release=%b expected all 0000",
                  bus_a.btn_level, bus_a.btn_press, bus_a.btn_release);
      end
      checks++;
      if (bus_a.h_sync !== 1'b1 || bus_a.v_sync !== 1'b1) begin
         errors++;
         $display("FAIL reset_sync: h=%b v=%b expected 1 1", bus_a.h_sync, bus_a.v_sync);
      end
      checks++;
      if (bus_a.rgb !== 16'h0 || bus_a.led !== 5'b0) begin
         errors++;
         $display("FAIL reset_rgb_led: rgb=%h led=%b expected 0000 00000", bus_a.rgb, bus_a.led);
      end
      checks++;
      if (bus_b.btn_level !== 4'b0 || bus_b.led !== 5'b0 || bus_b.h_sync !== 1'b1) begin
         errors++;
         $display("FAIL reset_low_inst: level=%b led=%b h=%b expected 0000 00000 1",
                  bus_b.btn_level, bus_b.led, bus_b.h_sync);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus_a.led !== 5'b00001) begin
         errors++;
         $display("FAIL idle_led: led=%b expected 00001", bus_a.led);
      end
   endtask

   task automatic test_clean_press();
      bus_a.btn_raw[0] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if (bus_a.btn_level[0] !== (k >= 6) || bus_a.btn_press[0] !== (k == 6)) begin
            errors++;
            $display("FAIL clean_press edge %0d: level=%b press=%b expected level=%b press=%b",
                     k, bus_a.btn_level[0], bus_a.btn_press[0], (k >= 6), (k == 6));
         end
      end
      checks++;
      if (bus_a.led !== 5'b00011) begin
         errors++;
         $display("FAIL clean_press_led: led=%b expected 00011", bus_a.led);
      end
   endtask

   task automatic test_bounce();
      int presses;
      presses = 0;
      for (int k = 1; k <= 14; k++) begin
         bus_a.btn_raw[1] = (k == 4) ? 1'b0 : 1'b1;
         tick();
         if (bus_a.btn_press[1] === 1'b1) presses++;
         checks++;
         if (bus_a.btn_level[1] !== (k >= 10) || bus_a.btn_press[1] !== (k == 10)) begin
            errors++;
            $display("FAIL bounce edge %0d: level=%b press=%b expected level=%b press=%b",
                     k, bus_a.btn_level[1], bus_a.btn_press[1], (k >= 10), (k == 10));
         end
      end
      checks++;
      if (presses != 1) begin
         errors++;
         $display("FAIL bounce_pulse_count: got %0d expected 1", presses);
      end
   endtask

   task automatic test_active_low();
      logic [3:0] exp_lvl, exp_prs, exp_rel;
      bus_b.btn_raw[2] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_lvl = (k >= 6) ? 4'b0100 : 4'b0000;
         exp_prs = (k == 6) ? 4'b0100 : 4'b0000;
         checks++;
         if (bus_b.btn_level !== exp_lvl || bus_b.btn_press !== exp_prs || bus_b.btn_release !== 4'b0) begin
            errors++;
            $display("FAIL active_low_press edge %0d: level=%b press=%b release=%b expected %b %b 0000",
                     k, bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, exp_lvl, exp_prs);
         end
      end
      bus_b.btn_raw[2] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_lvl = (k >= 6) ? 4'b0000 : 4'b0100;
         exp_rel = (k == 6) ? 4'b0100 : 4'b0000;
         checks++;
         if (bus_b.btn_level !== exp_lvl || bus_b.btn_release !== exp_rel || bus_b.btn_press !== 4'b0) begin
            errors++;
            $display("FAIL active_low_release edge %0d: level=%b press=%b release=%b expected %b 0000 %b",
                     k, bus_b.btn_level, bus_b.btn_press, bus_b.btn_release, exp_lvl, exp_rel);
         end
      end
   endtask

   task automatic test_video();
      logic [1:0]  rv [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
      logic [1:0]  gv [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
      logic [1:0]  bv [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
      logic        hs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic        vs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] ev [4] = '{16'h57E0, 16'h281F, 16'h7D55, 16'h02AA};
      for (int k = 0; k < 4; k++) begin
         bus_a.r_in = rv[k];
         bus_a.g_in = gv[k];
         bus_a.b_in = bv[k];
         bus_a.hsync_in = hs[k];
         bus_a.vsync_in = vs[k];
         #1;
         if (k > 0) begin
            checks++;
            if (bus_a.rgb !== ev[k-1] || bus_a.h_sync !== hs[k-1] || bus_a.v_sync !== vs[k-1]) begin
               errors++;
               $display("FAIL video_hold %0d: rgb=%h h=%b v=%b expected %h %b %b",
                        k, bus_a.rgb, bus_a.h_sync, bus_a.v_sync, ev[k-1], hs[k-1], vs[k-1]);
            end
         end
         tick();
         checks++;
         if (bus_a.rgb !== ev[k] || bus_a.h_sync !== hs[k] || bus_a.v_sync !== vs[k]) begin
            errors++;
            $display("FAIL video %0d: rgb=%h h=%b v=%b expected %h %b %b",
                     k, bus_a.rgb, bus_a.h_sync, bus_a.v_sync, ev[k], hs[k], vs[k]);
         end
      end
   endtask

   // Waits for a toggle of led[0], then returns cycles to the next toggle (-1 on timeout).
   task automatic measure(output int n);
      logic prev;
      bit   seen;
      n = -1;
      seen = 1'b0;
      prev = bus_a.led[0];
      for (int t = 0; t < 40 && !seen; t++) begin
         tick();
         if (bus_a.led[0] !== prev) seen = 1'b1;
      end
      if (seen) begin
         prev = bus_a.led[0];
         for (int c = 1; c <= 40 && n < 0; c++) begin
            tick();
            if (bus_a.led[0] !== prev) n = c;
         end
      end
   endtask

   task automatic test_status();
      int n;
      int bad;
      bus_a.game_end = 1'b1;
      tick();
      for (int r = 0; r < 2; r++) begin
         measure(n);
         checks++;
         if (n != 8) begin
            errors++;
            $display("FAIL slow_blink %0d: interval=%0d expected 8", r, n);
         end
      end
      bus_a.game_win = 1'b1;
      tick();
      for (int r = 0; r < 2; r++) begin
         measure(n);
         checks++;
         if (n != 4) begin
            errors++;
            $display("FAIL fast_blink %0d: interval=%0d expected 4", r, n);
         end
      end
      bus_a.game_end = 1'b0;
      bus_a.game_win = 1'b0;
      repeat (2) tick();
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus_a.led[0] !== 1'b1) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL steady_led: %0d cycles not 1, expected 0", bad);
      end
   endtask

   task automatic test_reset_mid_debounce();
      logic [3:0] exp_lvl, exp_prs;
      bus_a.hsync_in = 1'b0;
      bus_a.vsync_in = 1'b0;
      bus_a.btn_raw[3] = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (bus_a.btn_level !== 4'b0 || bus_a.btn_press !== 4'b0 || bus_a.btn_release !== 4'b0 ||
          bus_a.led !== 5'b0 || bus_a.rgb !== 16'h0) begin
         errors++;
         $display("FAIL midreset_state: level=%b press=%b release=%b led=%b rgb=%h expected zeros",
                  bus_a.btn_level, bus_a.btn_press, bus_a.btn_release, bus_a.led, bus_a.rgb);
      end
      checks++;
      if (bus_a.h_sync !== 1'b1 || bus_a.v_sync !== 1'b1) begin
         errors++;
         $display("FAIL midreset_sync: h=%b v=%b expected 1 1", bus_a.h_sync, bus_a.v_sync);
      end
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_lvl = (k >= 6) ? 4'b1011 : 4'b0000;
         exp_prs = (k == 6) ? 4'b1011 : 4'b0000;
         checks++;
         if (bus_a.btn_level !== exp_lvl || bus_a.btn_press !== exp_prs) begin
            errors++;
            $display("FAIL midreset_restart edge %0d: level=%b press=%b expected %b %b",
                     k, bus_a.btn_level, bus_a.btn_press, exp_lvl, exp_prs);
         end
      end
   endtask

   initial begin
      bus_a.btn_raw  = '0;
      bus_a.hsync_in = 1'b0;
      bus_a.vsync_in = 1'b0;
      bus_a.r_in     = '0;
      bus_a.g_in     = '0;
      bus_a.b_in     = '0;
      bus_a.game_end = 1'b0;
      bus_a.game_win = 1'b0;
      bus_b.btn_raw  = '1;
      bus_b.hsync_in = 1'b0;
      bus_b.vsync_in = 1'b0;
      bus_b.r_in     = '0;
      bus_b.g_in     = '0;
      bus_b.b_in     = '0;
      bus_b.game_end = 1'b0;
      bus_b.game_win = 1'b0;

      test_reset();
      test_clean_press();
      test_bounce();
      test_active_low();
      test_video();
      test_status();
      test_reset_mid_debounce();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
